// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit.
//   - Operation encodings as presented on op_i by the execute stage.
//   - Controller state enumeration.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldivState;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide datapath (purely combinational).
// Ports:
//   accIn   - 2*WIDTH accumulator: multiply {partial product, multiplier},
//             divide {partial remainder, remaining dividend/quotient}
//   operand - multiplicand (multiply) or divisor (divide) magnitude
//   isDiv   - 1 selects restoring divide, 0 selects shift-add multiply
//   accOut  - accumulator after this iteration (divide: LSB left 0)
//   qBit    - quotient bit produced by a divide step (0 when multiplying)
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] accIn,
    input  logic [WIDTH-1:0]   operand,
    input  logic               isDiv,
    output logic [2*WIDTH-1:0] accOut,
    output logic               qBit
);

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   divTrial;
    logic [WIDTH-1:0] divDiff;

    always_comb begin
        // Multiply: conditionally add multiplicand to the upper half, keep the
        // carry, then shift the whole accumulator right by one.
        mulSum   = {1'b0, accIn[2*WIDTH-1:WIDTH]}
                 + (accIn[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // The remainder is always below the divisor, so the difference fits
        // in WIDTH bits whenever the subtraction is kept.
        divTrial = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
        divDiff  = divTrial[WIDTH-1:0] - operand;
        qBit     = 1'b0;
        accOut   = '0;
        if (isDiv) begin
            qBit   = (divTrial >= {1'b0, operand});
            // Quotient bit is merged into the vacated LSB by the caller.
            accOut = {(qBit ? divDiff : divTrial[WIDTH-1:0]), accIn[WIDTH-2:0], 1'b0};
        end else begin
            accOut = {mulSum, accIn[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// An operation takes WIDTH+1 cycles after acceptance; the pipeline is stalled
// from the accept cycle through the last RUN cycle.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   start_i    - operation request from E stage (held while stall_o=1)
//   op_i       - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a_i, b_i   - rs/rt operands (multiplicand/multiplier, dividend/divisor)
//   flush_i    - cancel in-flight operation / block acceptance
//   hilo_we_i  - bit1 writes HI, bit0 writes LO with wdata_i (MTHI/MTLO)
//   wdata_i    - direct-write data
//   stall_o    - pipeline hold request
//   busy_o     - unit not idle
//   done_o     - one-cycle completion pulse
//   hi_o, lo_o - architectural HI/LO
module muldiv_hilo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic [1:0]       hilo_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    muldivState        state, nextState;
    logic [CW-1:0]     count;
    logic [2*WIDTH-1:0] acc, accNext;
    logic [WIDTH-1:0]  operand;
    logic              isDiv;
    logic              negResult;   // negate product / quotient
    logic              negRem;      // remainder follows dividend sign
    logic              stepQBit;
    logic              accept;
    logic              lastStep;

    logic              opSigned, opDiv, aNeg, bNeg;
    logic [WIDTH-1:0]  aMag, bMag;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]  resHi, resLo;
    logic [WIDTH-1:0]  hiReg, loReg;

    function automatic logic [WIDTH-1:0] condNegate(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] condNegateWide(input logic [2*WIDTH-1:0] v,
                                                          input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    function automatic logic isNegative(input logic signed [WIDTH-1:0] v,
                                        input logic isSigned);
        return isSigned && (v < 0);
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) uStep (
        .accIn   (acc),
        .operand (operand),
        .isDiv   (isDiv),
        .accOut  (accNext),
        .qBit    (stepQBit)
    );

    // Operand conditioning for the accept cycle.
    always_comb begin
        opSigned = (op_i == OP_MULT) || (op_i == OP_DIV);
        opDiv    = (op_i == OP_DIV) || (op_i == OP_DIVU);
        aNeg     = isNegative(a_i, opSigned);
        bNeg     = isNegative(b_i, opSigned);
        aMag     = condNegate(a_i, aNeg);
        bMag     = condNegate(b_i, bNeg);
    end

    assign accept   = (state == IDLE) && start_i && !flush_i;
    assign lastStep = (count == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = RUN;
            RUN:     if (flush_i) nextState = IDLE;
                     else if (lastStep) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        stall_o = accept || (state == RUN);
        busy_o  = (state != IDLE);
        done_o  = (state == DONE) && !flush_i;
    end

    // Iteration counter
    always_ff @(posedge clk) begin
        if (rst)                count <= '0;
        else if (accept)        count <= '0;
        else if (state == RUN)  count <= count + 1'b1;
    end

    // Datapath registers (no reset: only meaningful after an accept)
    always_ff @(posedge clk) begin
        if (accept) begin
            isDiv     <= opDiv;
            negResult <= aNeg ^ bNeg;
            negRem    <= aNeg;
            operand   <= opDiv ? bMag : aMag;
            acc       <= {{WIDTH{1'b0}}, (opDiv ? aMag : bMag)};
        end else if (state == RUN) begin
            acc <= accNext | {{(2*WIDTH-1){1'b0}}, stepQBit};
        end
    end

    // Sign correction of the raw magnitude result
    always_comb begin
        product = condNegateWide(acc, negResult);
        if (isDiv) begin
            resLo = condNegate(acc[WIDTH-1:0], negResult);
            resHi = condNegate(acc[2*WIDTH-1:WIDTH], negRem);
        end else begin
            resLo = product[WIDTH-1:0];
            resHi = product[2*WIDTH-1:WIDTH];
        end
    end

    // HI/LO: direct writes any time; a completing operation overrides them.
    always_ff @(posedge clk) begin
        if (rst) begin
            hiReg <= '0;
            loReg <= '0;
        end else begin
            if (hilo_we_i[1]) hiReg <= wdata_i;
            if (hilo_we_i[0]) loReg <= wdata_i;
            if (state == DONE && !flush_i) begin
                hiReg <= resHi;
                loReg <= resLo;
            end
        end
    end

    assign hi_o = hiReg;
    assign lo_o = loReg;

endmodule

// File: tb/tb_muldiv_hilo.sv
module tb_muldiv_hilo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [1:0]   op_i;
    logic [W-1:0] a_i, b_i;
    logic         flush_i;
    logic [1:0]   hilo_we_i;
    logic [W-1:0] wdata_i;
    logic         stall_o, busy_o, done_o;
    logic [W-1:0] hi_o, lo_o;

    int assertCnt = 0;
    int failCnt   = 0;

    muldiv_hilo #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .flush_i   (flush_i),
        .hilo_we_i (hilo_we_i),
        .wdata_i   (wdata_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expHi;
        logic [W-1:0] expLo;
    } vecT;

    vecT vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Issue an op at the current cycle (caller is #1 after a posedge) and
    // check latency, stall length, non-reacceptance and the HI/LO result.
    task automatic runOp(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] expHi, input logic [W-1:0] expLo);
        int stallCnt = 0;
        int doneCyc  = -1;
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (stall_o) stallCnt++;
            if (done_o) begin
                doneCyc = cyc;
                break;
            end
            nextCycle();
        end
        nextCycle();
        start_i = 1'b0;
        check("done_cycle", 64'(doneCyc), 64'(W + 1));
        check("stall_cycles", 64'(stallCnt), 64'(W + 1));
        check("busy_after_done", 64'(busy_o), 64'd0);
        check("hi", 64'(hi_o), 64'(expHi));
        check("lo", 64'(lo_o), 64'(expLo));
    endtask

    initial begin
        logic [W-1:0] hiSave, loSave;
        int doneSeen;

        vecs[0]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[5]  = '{2'b11, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vecs[6]  = '{2'b00, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[7]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8]  = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vecs[9]  = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[10] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

        rst = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
        flush_i = 1'b0; hilo_we_i = 2'b00; wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);

        // MTHI then MTLO in IDLE
        hilo_we_i = 2'b10; wdata_i = 32'h00001234;
        nextCycle();
        hilo_we_i = 2'b00;
        check("mthi_hi", 64'(hi_o), 64'h1234);
        check("mthi_lo_untouched", 64'(lo_o), 64'd0);
        hilo_we_i = 2'b01; wdata_i = 32'h00005678;
        nextCycle();
        hilo_we_i = 2'b00;
        check("mtlo_lo", 64'(lo_o), 64'h5678);
        check("mtlo_hi_untouched", 64'(hi_o), 64'h1234);

        // Table vectors, issued back-to-back
        for (int i = 0; i < 11; i++)
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo);

        // Direct writes coincident with DONE: the operation result wins
        op_i = 2'b01; a_i = 32'd2; b_i = 32'd3; start_i = 1'b1;
        doneSeen = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (done_o) begin
                doneSeen = 1;
                hilo_we_i = 2'b11; wdata_i = 32'h0000DEAD;
                break;
            end
            nextCycle();
        end
        nextCycle();
        start_i = 1'b0; hilo_we_i = 2'b00;
        check("collide_done_seen", 64'(doneSeen), 64'd1);
        check("collide_lo", 64'(lo_o), 64'd6);
        check("collide_hi", 64'(hi_o), 64'd0);

        // Flush in RUN at cycle 10
        hiSave = hi_o; loSave = lo_o;
        op_i = 2'b01; a_i = 32'd6; b_i = 32'd7; start_i = 1'b1;
        doneSeen = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (done_o) doneSeen++;
            nextCycle();
        end
        check("flush_busy_before", 64'(busy_o), 64'd1);
        flush_i = 1'b1; start_i = 1'b0;
        nextCycle();
        flush_i = 1'b0;
        check("flush_idle", 64'(busy_o), 64'd0);
        check("flush_stall", 64'(stall_o), 64'd0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done_o) doneSeen++;
            nextCycle();
        end
        check("flush_no_done", 64'(doneSeen), 64'd0);
        check("flush_hi_kept", 64'(hi_o), 64'(hiSave));
        check("flush_lo_kept", 64'(lo_o), 64'(loSave));
        runOp(2'b01, 32'd6, 32'd7, 32'd0, 32'd42);

        // Reset in RUN at cycle 5
        op_i = 2'b01; a_i = 32'h0000FFFF; b_i = 32'h0000FFFF; start_i = 1'b1;
        repeat (5) nextCycle();
        check("rstrun_busy_before", 64'(busy_o), 64'd1);
        rst = 1'b1; start_i = 1'b0;
        nextCycle();
        rst = 1'b0;
        check("rstrun_hi", 64'(hi_o), 64'd0);
        check("rstrun_lo", 64'(lo_o), 64'd0);
        check("rstrun_busy", 64'(busy_o), 64'd0);
        check("rstrun_stall", 64'(stall_o), 64'd0);
        check("rstrun_done", 64'(done_o), 64'd0);
        runOp(2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
